// File: rtl/pc_fetch_control_pkg.sv
// Shared definitions for the fetch-stage controller: opcode encodings,
// the NOP instruction word, the default reset PC and a PC increment helper.
package pc_fetch_control_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_BEQ  = 4'h8,
    OP_BNE  = 4'h9,
    OP_JMP  = 4'hA,
    OP_CALL = 4'hB,
    OP_RET  = 4'hC,
    OP_FOR  = 4'hD
  } opcode_e;

  localparam logic [15:0] NOP_INSTR        = 16'h0000;
  localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;

  // Sequential successor of a PC; wraps from 16'hFFFF to 16'h0000.
  function automatic logic [15:0] pc_incr(input logic [15:0] pc);
    return pc + 16'h0001;
  endfunction

endpackage

// File: rtl/pc_fetch_control_ras.sv
// Circular return-address stack. A push onto a full stack overwrites the
// oldest entry; the caller decides what to return on an empty pop.
module return_addr_stack
  #(
    parameter int RAS_DEPTH = 4
  )
  (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic        pop,
    input  logic [15:0] push_data,
    output logic [15:0] pop_data,
    output logic        full,
    output logic        empty
  );

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RAS_DEPTH);

  logic [15:0]      mem_r [RAS_DEPTH];
  logic [PTR_W-1:0] top_r;
  logic [CNT_W-1:0] count_r;
  logic [PTR_W-1:0] push_ptr_s;

  assign push_ptr_s = top_r + PTR_ONE;
  assign pop_data   = mem_r[top_r];
  assign full       = (count_r == DEPTH_C);
  assign empty      = (count_r == {CNT_W{1'b0}});

  // Stack storage, top pointer and occupancy; push wins if both are requested.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RAS_DEPTH; i++) begin
        mem_r[i] <= 16'h0000;
      end
      top_r   <= {PTR_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
    end else if (push) begin
      mem_r[push_ptr_s] <= push_data;
      top_r             <= push_ptr_s;
      if (!full) begin
        count_r <= count_r + CNT_ONE;
      end
    end else if (pop) begin
      if (!empty) begin
        top_r   <= top_r - PTR_ONE;
        count_r <= count_r - CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/pc_fetch_control.sv
// Fetch-stage controller: owns the PC, the IF/ID register and the return
// address stack, and turns decode redirects into a new PC plus one bubble.
module pc_fetch_control
  import pc_fetch_control_pkg::*;
  #(
    parameter int          RAS_DEPTH = 4,
    parameter logic [15:0] RESET_PC  = RESET_PC_DEFAULT
  )
  (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        kill,
    input  logic [3:0]  op_d,
    input  logic [15:0] pc_d,
    input  logic [15:0] branch_target,
    input  logic [15:0] jump_target,
    input  logic [15:0] imem_instr,
    output logic [15:0] pc_f,
    output logic [15:0] ifid_instr,
    output logic [15:0] ifid_pc,
    output logic        ifid_valid,
    output logic        ras_overflow,
    output logic        ras_underflow
  );

  logic [15:0] pc_f_r, ifid_instr_r, ifid_pc_r;
  logic        ifid_valid_r, ras_overflow_r, ras_underflow_r;

  logic [15:0] pc_next_s, ifid_instr_next_s, ifid_pc_next_s;
  logic        ifid_valid_next_s;
  logic        push_s, pop_s;
  logic [15:0] ras_pop_data_s;
  logic        ras_full_s, ras_empty_s;

  return_addr_stack #(.RAS_DEPTH(RAS_DEPTH)) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_s),
    .pop       (pop_s),
    .push_data (pc_incr(pc_d)),
    .pop_data  (ras_pop_data_s),
    .full      (ras_full_s),
    .empty     (ras_empty_s)
  );

  // Next-PC / IF/ID selection with priority stall > kill > sequential fetch.
  always_comb begin
    pc_next_s         = pc_f_r;
    ifid_instr_next_s = ifid_instr_r;
    ifid_pc_next_s    = ifid_pc_r;
    ifid_valid_next_s = ifid_valid_r;
    push_s            = 1'b0;
    pop_s             = 1'b0;
    if (stall) begin
      pc_next_s = pc_f_r;
    end else if (kill) begin
      ifid_instr_next_s = NOP_INSTR;
      ifid_pc_next_s    = 16'h0000;
      ifid_valid_next_s = 1'b0;
      case (op_d)
        OP_BEQ, OP_BNE: pc_next_s = branch_target;
        OP_JMP, OP_FOR: pc_next_s = jump_target;
        OP_CALL: begin
          pc_next_s = jump_target;
          push_s    = 1'b1;
        end
        OP_RET: begin
          pop_s = 1'b1;
          if (ras_empty_s) begin
            pc_next_s = RESET_PC;
          end else begin
            pc_next_s = ras_pop_data_s;
          end
        end
        default: pc_next_s = jump_target;
      endcase
    end else begin
      pc_next_s         = pc_incr(pc_f_r);
      ifid_instr_next_s = imem_instr;
      ifid_pc_next_s    = pc_f_r;
      ifid_valid_next_s = 1'b1;
    end
  end

  // PC and IF/ID pipeline registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_f_r       <= RESET_PC;
      ifid_instr_r <= NOP_INSTR;
      ifid_pc_r    <= 16'h0000;
      ifid_valid_r <= 1'b0;
    end else begin
      pc_f_r       <= pc_next_s;
      ifid_instr_r <= ifid_instr_next_s;
      ifid_pc_r    <= ifid_pc_next_s;
      ifid_valid_r <= ifid_valid_next_s;
    end
  end

  // Sticky stack-misuse flags; only reset clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ras_overflow_r  <= 1'b0;
      ras_underflow_r <= 1'b0;
    end else begin
      if (push_s && ras_full_s) begin
        ras_overflow_r <= 1'b1;
      end
      if (pop_s && ras_empty_s) begin
        ras_underflow_r <= 1'b1;
      end
    end
  end

  assign pc_f          = pc_f_r;
  assign ifid_instr    = ifid_instr_r;
  assign ifid_pc       = ifid_pc_r;
  assign ifid_valid    = ifid_valid_r;
  assign ras_overflow  = ras_overflow_r;
  assign ras_underflow = ras_underflow_r;

endmodule

// File: tb/tb_pc_fetch_control.sv
// Bench for pc_fetch_control: directed scenarios followed by random
// stall/kill/opcode traffic, all checked against a queue-based model.
module tb_pc_fetch_control;
  import pc_fetch_control_pkg::*;

  localparam int          RAS_DEPTH = 4;
  localparam logic [15:0] RESET_PC  = 16'h0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, kill;
  logic [3:0]  op_d;
  logic [15:0] pc_d, branch_target, jump_target, imem_instr;
  logic [15:0] pc_f, ifid_instr, ifid_pc;
  logic        ifid_valid, ras_overflow, ras_underflow;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model state
  logic [15:0] m_pc, m_instr, m_ifpc;
  logic        m_valid, m_ovf, m_unf;
  logic [15:0] m_ras[$];

  pc_fetch_control #(.RAS_DEPTH(RAS_DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .kill(kill), .op_d(op_d),
    .pc_d(pc_d), .branch_target(branch_target), .jump_target(jump_target),
    .imem_instr(imem_instr), .pc_f(pc_f), .ifid_instr(ifid_instr),
    .ifid_pc(ifid_pc), .ifid_valid(ifid_valid),
    .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
  );

  always #5 clk = ~clk;

  // Instruction memory contents: a fixed scramble of the address.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  assign imem_instr = mem_word(pc_f);

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ".pc_f"}, pc_f, m_pc);
    check_eq({tag, ".ifid_instr"}, ifid_instr, m_instr);
    check_eq({tag, ".ifid_pc"}, ifid_pc, m_ifpc);
    check_eq({tag, ".ifid_valid"}, {15'h0000, ifid_valid}, {15'h0000, m_valid});
    check_eq({tag, ".ovf"}, {15'h0000, ras_overflow}, {15'h0000, m_ovf});
    check_eq({tag, ".unf"}, {15'h0000, ras_underflow}, {15'h0000, m_unf});
  endtask

  task automatic model_reset();
    m_pc = RESET_PC; m_instr = 16'h0000; m_ifpc = 16'h0000;
    m_valid = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    m_ras.delete();
  endtask

  // One clock of the architectural behaviour.
  task automatic model_step(input logic s, input logic k, input logic [3:0] op,
                            input logic [15:0] pcd, input logic [15:0] bt, input logic [15:0] jt);
    logic [15:0] npc;
    if (s) return;
    if (k) begin
      if (op == OP_BEQ || op == OP_BNE) npc = bt;
      else if (op == OP_RET) begin
        if (m_ras.size() == 0) begin
          npc = RESET_PC;
          m_unf = 1'b1;
        end else begin
          npc = m_ras.pop_back();
        end
      end else begin
        npc = jt;
        if (op == OP_CALL) begin
          if (m_ras.size() == RAS_DEPTH) begin
            void'(m_ras.pop_front());
            m_ovf = 1'b1;
          end
          m_ras.push_back(pcd + 16'h0001);
        end
      end
      m_instr = 16'h0000; m_ifpc = 16'h0000; m_valid = 1'b0;
    end else begin
      m_instr = mem_word(m_pc); m_ifpc = m_pc; m_valid = 1'b1;
      npc = m_pc + 16'h0001;
    end
    m_pc = npc;
  endtask

  task automatic step(input string tag, input logic s, input logic k, input logic [3:0] op,
                      input logic [15:0] pcd, input logic [15:0] bt, input logic [15:0] jt);
    stall = s; kill = k; op_d = op; pc_d = pcd; branch_target = bt; jump_target = jt;
    @(posedge clk);
    model_step(s, k, op, pcd, bt, jt);
    #1;
    check_all(tag);
  endtask

  task automatic seq(input string tag);
    step(tag, 1'b0, 1'b0, OP_NOP, 16'h0000, 16'h0000, 16'h0000);
  endtask

  initial begin
    logic [3:0]  rop;
    logic        rs, rk;
    rst_n = 1'b0; stall = 1'b0; kill = 1'b0; op_d = 4'h0;
    pc_d = 16'h0000; branch_target = 16'h0000; jump_target = 16'h0000;
    #12;
    model_reset();
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Free run from reset
    for (int i = 0; i < 4; i++) seq("freerun");

    // Taken branch: one bubble then the target instruction
    step("beq", 1'b0, 1'b1, OP_BEQ, 16'h0003, 16'h0040, 16'h0999);
    seq("beq_t1");
    seq("beq_t2");

    // Single CALL / RET pair
    step("call", 1'b0, 1'b1, OP_CALL, 16'h0010, 16'h0000, 16'h0100);
    seq("call_body");
    step("ret", 1'b0, 1'b1, OP_RET, 16'h0101, 16'h0000, 16'h0000);
    seq("ret_t1");

    // Five nested calls on a four-entry stack, then six returns
    for (int i = 0; i < 5; i++)
      step("ncall", 1'b0, 1'b1, OP_CALL, 16'h0200 + 16'(i * 16), 16'h0000, 16'h0300 + 16'(i));
    for (int i = 0; i < 6; i++)
      step("nret", 1'b0, 1'b1, OP_RET, 16'h0000, 16'h0000, 16'h0000);

    // Stall overrides kill, redirect after the stall drops
    seq("pre_stall");
    step("stall_kill", 1'b1, 1'b1, OP_JMP, 16'h0000, 16'h0000, 16'h0500);
    step("stall_kill", 1'b1, 1'b1, OP_JMP, 16'h0000, 16'h0000, 16'h0500);
    step("kill_go", 1'b0, 1'b1, OP_JMP, 16'h0000, 16'h0000, 16'h0500);
    seq("kill_go_t1");

    // PC wrap-around
    step("to_ffff", 1'b0, 1'b1, OP_FOR, 16'h0000, 16'h0000, 16'hFFFF);
    seq("wrap1");
    seq("wrap2");

    // Asynchronous reset in the middle of a CALL cycle
    step("pre_rst_call", 1'b0, 1'b1, OP_CALL, 16'h0700, 16'h0000, 16'h0800);
    stall = 1'b0; kill = 1'b1; op_d = OP_CALL; pc_d = 16'h0900; jump_target = 16'h0A00;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    step("rst_ret", 1'b0, 1'b1, OP_RET, 16'h0000, 16'h0000, 16'h0000);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      rs = ($urandom_range(0, 4) == 0);
      rk = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 7))
        0: rop = OP_BEQ;
        1: rop = OP_BNE;
        2: rop = OP_JMP;
        3, 4: rop = OP_CALL;
        5: rop = OP_RET;
        6: rop = OP_FOR;
        default: rop = 4'($urandom_range(0, 15));
      endcase
      step("rand", rs, rk, rop, 16'($urandom), 16'($urandom), 16'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
